// File: rtl/record_fifo_pkg.sv
// record_fifo_pkg
//   Shared types and width helpers for the record FIFO and the MotionSegment
//   segment loader that consumes its records.
//   - fifo_state_t : occupancy state of the record FIFO
//   - record_w()   : record width in bits (RECORD_WORDS * IN_WIDTH)
//   - level_w()    : width of the fill-level counter for a given depth
//   - wcnt_w()     : width of the word counter inside the assembler
//   - ptr_w()      : width of the wrapping read/write pointers
//   - MSEG_*       : record layout used by the MotionSegment loader
package record_fifo_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } fifo_state_t;

  function automatic int record_w(input int in_width, input int record_words);
    return in_width * record_words;
  endfunction

  function automatic int level_w(input int slots);
    return $clog2(slots + 1);
  endfunction

  function automatic int wcnt_w(input int record_words);
    return $clog2(record_words);
  endfunction

  // One extra bit over the slot index so the pointers wrap naturally.
  function automatic int ptr_w(input int slots);
    return $clog2(slots) + 1;
  endfunction

  // Bit offset of word idx inside a record; word 0 is the least significant.
  function automatic int word_lsb(input int idx, input int in_width);
    return idx * in_width;
  endfunction

  // MotionSegment record layout: 16 bytes per segment, 32 segments buffered.
  localparam int MSEG_IN_WIDTH     = 8;
  localparam int MSEG_RECORD_WORDS = 16;
  localparam int MSEG_SLOTS        = 32;
  localparam int MSEG_RECORD_W     = record_w(MSEG_IN_WIDTH, MSEG_RECORD_WORDS);

  typedef logic [level_w(MSEG_SLOTS)-1:0]        level_t;
  typedef logic [wcnt_w(MSEG_RECORD_WORDS)-1:0]  wcnt_t;

endpackage

// File: rtl/record_assembler.sv
// record_assembler
//   Collects IN_WIDTH-bit words into a RECORD_WORDS-word record.
//   Ports:
//     clk, rst       clock, asynchronous active-low reset
//     accept         a word is transferred this cycle (in_valid && in_ready)
//     in_data        input word
//     in_last        sender marks the final word of a record
//     in_abort       drop the partial record (and any word accepted with it)
//     flush          drop the partial record
//     commit         strobe: record is complete this cycle
//     record         complete record, valid while commit is high
//     err_short      one-cycle pulse after a record closed early by in_last
module record_assembler
  import record_fifo_pkg::*;
#(
  parameter int IN_WIDTH     = 8,
  parameter int RECORD_WORDS = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      accept,
  input  logic [IN_WIDTH-1:0]                       in_data,
  input  logic                                      in_last,
  input  logic                                      in_abort,
  input  logic                                      flush,
  output logic                                      commit,
  output logic [record_w(IN_WIDTH, RECORD_WORDS)-1:0] record,
  output logic                                      err_short
);

  localparam int WCNT_W = wcnt_w(RECORD_WORDS);
  localparam int LOW_W  = (RECORD_WORDS - 1) * IN_WIDTH;
  localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(RECORD_WORDS - 1);

  logic [WCNT_W-1:0] wcnt_p0;
  logic [LOW_W-1:0]  asm_p0;
  logic              at_last;
  logic              take;
  logic              short_rec;

  // An aborted or flushed word is never stored, so it can neither commit
  // nor raise a short-record error.
  assign at_last   = (wcnt_p0 == LAST_IDX);
  assign take      = accept && !flush && !in_abort;
  assign commit    = take && at_last;
  assign short_rec = take && in_last && !at_last;

  // The final word bypasses the assembly register and joins the record here.
  assign record = {in_data, asm_p0};

  // ---- stage p0: word counter and error flag ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_p0   <= '0;
      err_short <= 1'b0;
    end else begin
      err_short <= short_rec;
      if (flush || in_abort || commit || short_rec) begin
        wcnt_p0 <= '0;
      end else if (take) begin
        wcnt_p0 <= wcnt_p0 + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RECORD_WORDS - 1; i++) begin
      if (take && (wcnt_p0 == WCNT_W'(i))) begin
        asm_p0[word_lsb(i, IN_WIDTH) +: IN_WIDTH] <= in_data;
      end
    end
  end

endmodule

// File: rtl/record_fifo.sv
// record_fifo
//   Assembles input words into fixed-size records, queues up to SLOTS records
//   and presents the head record through a registered valid/ready output.
//   Ports:
//     clk, rst              clock, asynchronous active-low reset
//     in_valid/in_ready     input word handshake
//     in_data, in_last      input word and end-of-record marker
//     in_abort              drop the partially assembled record
//     flush                 drop everything, including queued records
//     out_valid/out_ready   output record handshake
//     out_record            head record, word 0 in the low bits
//     level                 committed records, including the presented one
//     almost_full           level >= ALMOST_FULL
//     err_short             pulse after a record closed early by in_last
module record_fifo
  import record_fifo_pkg::*;
#(
  parameter int IN_WIDTH     = 8,
  parameter int RECORD_WORDS = 16,
  parameter int SLOTS        = 32,
  parameter int ALMOST_FULL  = SLOTS - 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  input  logic [IN_WIDTH-1:0]                         in_data,
  input  logic                                        in_last,
  output logic                                        in_ready,
  input  logic                                        in_abort,
  input  logic                                        flush,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [record_w(IN_WIDTH, RECORD_WORDS)-1:0] out_record,
  output logic [level_w(SLOTS)-1:0]                   level,
  output logic                                        almost_full,
  output logic                                        err_short
);

  localparam int REC_W   = record_w(IN_WIDTH, RECORD_WORDS);
  localparam int LEVEL_W = level_w(SLOTS);
  localparam int PTR_W   = ptr_w(SLOTS);
  localparam int IDX_W   = PTR_W - 1;
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(SLOTS);
  localparam logic [LEVEL_W-1:0] LEVEL_AF   = LEVEL_W'(ALMOST_FULL);

  logic               accept;
  logic               commit_p0;
  logic [REC_W-1:0]   record_p0;

  logic [REC_W-1:0]   mem [SLOTS];
  logic [PTR_W-1:0]   wptr_q;
  logic [PTR_W-1:0]   rptr_q;
  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_nxt;
  logic [LEVEL_W-1:0] queued;
  logic               pop;
  logic               load;

  logic               out_valid_p1;
  logic [REC_W-1:0]   out_record_p1;

  fifo_state_t        state_q;
  fifo_state_t        state_nxt;

  assign in_ready = (state_q != ST_FULL) && !flush;
  assign accept   = in_valid && in_ready;

  record_assembler #(
    .IN_WIDTH     (IN_WIDTH),
    .RECORD_WORDS (RECORD_WORDS)
  ) u_assembler (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_abort  (in_abort),
    .flush     (flush),
    .commit    (commit_p0),
    .record    (record_p0),
    .err_short (err_short)
  );

  // Records sitting in storage behind the output register. A record committed
  // this cycle is not counted yet, which gives the output its one-cycle stage.
  assign queued = level_q - {{(LEVEL_W-1){1'b0}}, out_valid_p1};
  assign pop    = out_valid_p1 && out_ready;
  assign load   = (queued != '0) && (!out_valid_p1 || pop);

  always_comb begin
    level_nxt = level_q;
    case ({commit_p0, pop})
      2'b10:   level_nxt = level_q + 1'b1;
      2'b01:   level_nxt = level_q - 1'b1;
      default: level_nxt = level_q;
    endcase
  end

  // State mirrors level; in_ready is taken from it so FULL is a registered flag.
  always_comb begin
    state_nxt = state_q;
    if (flush || (level_nxt == '0)) begin
      state_nxt = ST_EMPTY;
    end else if (level_nxt == LEVEL_FULL) begin
      state_nxt = ST_FULL;
    end else begin
      state_nxt = ST_ACTIVE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  // ---- stage p0 -> storage: commit writes the completed record ----
  always_ff @(posedge clk) begin
    if (commit_p0) begin
      mem[wptr_q[IDX_W-1:0]] <= record_p0;
    end
  end

  // ---- stage p1: pointers, level and output register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      level_q       <= '0;
      out_valid_p1  <= 1'b0;
      out_record_p1 <= '0;
    end else if (flush) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      level_q       <= '0;
      out_valid_p1  <= 1'b0;
      out_record_p1 <= '0;
    end else begin
      level_q <= level_nxt;
      if (commit_p0) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (load) begin
        out_record_p1 <= mem[rptr_q[IDX_W-1:0]];
        out_valid_p1  <= 1'b1;
        rptr_q        <= rptr_q + 1'b1;
      end else if (pop) begin
        out_valid_p1  <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_p1;
  assign out_record  = out_record_p1;
  assign level       = level_q;
  assign almost_full = (level_q >= LEVEL_AF);

endmodule

// File: tb/tb_record_fifo.sv
module tb_record_fifo;

  localparam int IW    = 8;
  localparam int RW    = 4;
  localparam int SLOTS = 4;
  localparam int AF    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          in_abort;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_record;
  logic [2:0]    level;
  logic          almost_full;
  logic          err_short;

  int checks = 0;
  int errors = 0;

  // Reference model: list of committed records and list of pending words.
  logic [31:0] fifo [$];
  logic [7:0]  part [$];
  bit          m_ovalid;
  logic [31:0] m_orec;
  bit          m_err;

  always #5 clk = ~clk;

  record_fifo #(
    .IN_WIDTH     (IW),
    .RECORD_WORDS (RW),
    .SLOTS        (SLOTS),
    .ALMOST_FULL  (AF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .in_abort    (in_abort),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_record  (out_record),
    .level       (level),
    .almost_full (almost_full),
    .err_short   (err_short)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_words();
    logic [31:0] r = '0;
    for (int i = 0; i < RW; i++) r |= 32'(part[i]) << (8 * i);
    return r;
  endfunction

  task automatic model_clear();
    fifo.delete();
    part.delete();
    m_ovalid = 1'b0;
    m_orec   = '0;
    m_err    = 1'b0;
  endtask

  task automatic check_outputs();
    check("level", level, fifo.size());
    check("out_valid", out_valid, m_ovalid);
    check("out_record", out_record, m_orec);
    check("almost_full", almost_full, fifo.size() >= AF);
    check("err_short", err_short, m_err);
  endtask

  // One clock cycle: drive inputs, predict, advance, compare.
  task automatic step(input bit v, input logic [7:0] d, input bit l,
                      input bit ab, input bit fl, input bit ordy);
    bit m_ready, acc, pop;
    int base;
    in_valid = v; in_data = d; in_last = l;
    in_abort = ab; flush = fl; out_ready = ordy;
    #1;
    m_ready = (fifo.size() != SLOTS) && !fl;
    check("in_ready", in_ready, m_ready);
    acc   = v && m_ready;
    m_err = 1'b0;
    if (fl) begin
      model_clear();
    end else begin
      pop = m_ovalid && ordy;
      if (pop) void'(fifo.pop_front());
      base = fifo.size();
      if (ab) begin
        part.delete();
      end else if (acc) begin
        part.push_back(d);
        if (part.size() == RW) begin
          fifo.push_back(pack_words());
          part.delete();
        end else if (l) begin
          part.delete();
          m_err = 1'b1;
        end
      end
      m_ovalid = (base > 0);
      if (m_ovalid) m_orec = fifo[0];
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic push_word(input logic [7:0] d, input bit l, input bit ordy);
    step(1'b1, d, l, 1'b0, 1'b0, ordy);
  endtask

  task automatic push_rand_record(input bit ordy);
    for (int i = 0; i < RW; i++) push_word(8'($urandom), i == RW - 1, ordy);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (fifo.size() != 0 || out_valid); i++) idle(1'b1);
    check("drained_level", level, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_record"}, out_record, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_almost_full"}, almost_full, 0);
    check({tag, "_err_short"}, err_short, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_abort = 1'b0; flush = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Basic record
    push_word(8'h11, 1'b0, 1'b0);
    push_word(8'h22, 1'b0, 1'b0);
    push_word(8'h33, 1'b0, 1'b0);
    push_word(8'h44, 1'b1, 1'b0);
    check("basic_level_at_commit", level, 1);
    check("basic_ovalid_at_commit", out_valid, 0);
    idle(1'b0);
    check("basic_out_valid", out_valid, 1);
    check("basic_out_record", out_record, 32'h44332211);
    idle(1'b1);
    check("basic_popped", level, 0);

    // Fill to full
    for (int r = 0; r < SLOTS; r++) push_rand_record(1'b0);
    in_valid = 1'b1;
    #1;
    check("full_level", level, 4);
    check("full_in_ready", in_ready, 0);
    check("full_almost", almost_full, 1);
    push_word(8'h5A, 1'b0, 1'b0);
    check("full_reject_level", level, 4);
    idle(1'b1);
    check("full_pop_level", level, 3);
    check("full_pop_ready", in_ready, 1);
    drain();

    // Short record then clean record
    push_word(8'hAA, 1'b0, 1'b0);
    push_word(8'hBB, 1'b1, 1'b0);
    idle(1'b0);
    check("short_level", level, 0);
    push_rand_record(1'b0);
    idle(1'b0);
    check("short_then_clean", level, 1);
    drain();

    // Abort with a word in the same cycle
    push_word(8'h01, 1'b0, 1'b0);
    push_word(8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    check("abort_err", err_short, 0);
    push_word(8'hC1, 1'b0, 1'b0);
    push_word(8'hC2, 1'b0, 1'b0);
    push_word(8'hC3, 1'b0, 1'b0);
    push_word(8'hC4, 1'b0, 1'b0);
    idle(1'b0);
    check("abort_clean_record", out_record, 32'hC4C3C2C1);
    drain();

    // Commit and pop together at level 2, then stream with wrap
    push_rand_record(1'b0);
    push_rand_record(1'b0);
    idle(1'b0);
    for (int i = 0; i < RW - 1; i++) push_word(8'($urandom), 1'b0, 1'b0);
    check("pre_simul_level", level, 2);
    push_word(8'h77, 1'b0, 1'b1);
    check("simul_level", level, 2);
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < RW; i++) push_word(8'($urandom), 1'b0, 1'($urandom_range(0, 3) != 0));
    end
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 2) == 0));
    end
    drain();

    // Flush at level 3 with two words pending
    for (int r = 0; r < 3; r++) push_rand_record(1'b0);
    push_word(8'hD1, 1'b0, 1'b0);
    push_word(8'hD2, 1'b0, 1'b0);
    check("preflush_level", level, 3);
    step(1'b1, 8'hD3, 1'b0, 1'b0, 1'b1, 1'b0);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check_reset_values("flush");
    push_rand_record(1'b0);
    idle(1'b0);
    check("post_flush_record", level, 1);
    drain();

    // Asynchronous reset mid-record
    push_rand_record(1'b0);
    push_word(8'hE1, 1'b0, 1'b0);
    push_word(8'hE2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_clear();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_release_err", err_short, 0);
    push_word(8'hF3, 1'b1, 1'b0);
    idle(1'b0);
    push_rand_record(1'b0);
    idle(1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
